if_id_pipeline: RTL and testbench

Fetch stage plus IF/ID pipeline register. It owns the program counter, issues word fetches to instruction memory and latches each fetched instruction with its PC. The result feeds the ID stage, whose decoded operands and instruction go to the ID/EXE register.
It handles hazard-unit stalls, taken-branch redirects from EXE with flush, and instruction-memory wait cycles.

---
 rtl/if_id_pipeline.sv | 94 +++++++++
 tb/tb_if_id_pipeline.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/if_id_pipeline.sv
// Fetch stage with program counter and IF/ID pipeline register.
// Optional performance counters are enabled by defining IF_ID_PERF_CNT_EN.
module if_id_pipeline #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] ID_instruction,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_PC4,
`ifdef IF_ID_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles,
    output logic [31:0] perf_stalls,
`endif
    output logic        ID_valid
);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t      state, state_nxt;
    logic [29:0] pc_word;
    logic [31:0] pc;
    logic        do_branch, do_stall, do_fetch, do_bubble;

    // PC is kept word-aligned by storing only the word index.
    assign pc        = {pc_word, 2'b00};
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = FETCH;
        imem_req  = 1'b0;
        do_branch = 1'b0;
        do_stall  = 1'b0;
        do_fetch  = 1'b0;
        do_bubble = 1'b0;
        if (state == FETCH) begin
            imem_req = 1'b1;
            if (branch_taken)    do_branch = 1'b1;
            else if (stall)      do_stall  = 1'b1;
            else if (imem_ready) do_fetch  = 1'b1;
            else                 do_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_word        <= RESET_PC[31:2];
            ID_instruction <= NOP_INSTR;
            ID_PC          <= 32'h0;
            ID_PC4         <= 32'h0;
            ID_valid       <= 1'b0;
        end else if (do_fetch) begin
            ID_instruction <= imem_data;
            ID_PC          <= pc;
            ID_PC4         <= pc + 32'd4;
            ID_valid       <= 1'b1;
            pc_word        <= pc_word + 30'd1;
        end else if (!do_stall) begin
            // Branch, memory wait and IDLE all leave a bubble in IF/ID.
            ID_instruction <= NOP_INSTR;
            ID_valid       <= 1'b0;
            if (do_branch) pc_word <= branch_target[31:2];
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= 32'h0;
            perf_bubbles <= 32'h0;
            perf_stalls  <= 32'h0;
        end else begin
            if (do_fetch)              perf_fetched <= perf_fetched + 32'd1;
            if (do_branch | do_bubble) perf_bubbles <= perf_bubbles + 32'd1;
            if (do_stall)              perf_stalls  <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_pipeline.sv
// Directed bench for if_id_pipeline; memory returns address ^ 32'hA5A5_0000.
module tb_if_id_pipeline;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, branch_taken, imem_ready;
    logic [31:0] branch_target, imem_data;
    logic        imem_req;
    logic [31:0] imem_addr, ID_instruction, ID_PC, ID_PC4;
    logic        ID_valid;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubbles, perf_stalls;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_data = imem_addr ^ 32'hA5A5_0000;

    if_id_pipeline dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_ready     (imem_ready),
        .imem_data      (imem_data),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .ID_instruction (ID_instruction),
        .ID_PC          (ID_PC),
        .ID_PC4         (ID_PC4),
`ifdef IF_ID_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles),
        .perf_stalls    (perf_stalls),
`endif
        .ID_valid       (ID_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_id(input string tag, input logic [31:0] pc, input logic vld);
        check({tag, ".pc"},  ID_PC, pc);
        check({tag, ".pc4"}, ID_PC4, pc + 32'd4);
        check({tag, ".vld"}, {31'h0, ID_valid}, {31'h0, vld});
        check({tag, ".ins"}, ID_instruction, vld ? (pc ^ 32'hA5A5_0000) : 32'h0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; imem_ready = 1'b1;
        @(negedge clk);
        check("rst.vld",  {31'h0, ID_valid}, 32'h0);
        check("rst.pc",   ID_PC, 32'h0);
        check("rst.pc4",  ID_PC4, 32'h0);
        check("rst.ins",  ID_instruction, 32'h0);
        check("rst.req",  {31'h0, imem_req}, 32'h0);
        check("rst.addr", imem_addr, 32'h0);

        // IDLE ignores stall and branch
        reset = 1'b0; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        check("idle.req",  {31'h0, imem_req}, 32'h1);
        check("idle.addr", imem_addr, 32'h0);
        check("idle.vld",  {31'h0, ID_valid}, 32'h0);
        stall = 1'b0; branch_taken = 1'b0;

        tick(); check_id("f0", 32'h0, 1'b1);
        tick(); check_id("f4", 32'h4, 1'b1);
        tick(); check_id("f8", 32'h8, 1'b1);
        check("f8.addr", imem_addr, 32'hC);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_id("stl", 32'h8, 1'b1);
            check("stl.addr", imem_addr, 32'hC);
        end
        stall = 1'b0;
        tick(); check_id("rel", 32'hC, 1'b1);

        // branch wins over stall, target low bits dropped
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0103;
        tick();
        check("br.vld",  {31'h0, ID_valid}, 32'h0);
        check("br.ins",  ID_instruction, 32'h0);
        check("br.addr", imem_addr, 32'h100);
        check("br.pc",   ID_PC, 32'hC);
        stall = 1'b0; branch_taken = 1'b0;
        tick(); check_id("br100", 32'h100, 1'b1);

        branch_taken = 1'b1; branch_target = 32'h20;
        tick(); check("br20.addr", imem_addr, 32'h20);
        branch_taken = 1'b0; imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("wait.vld",  {31'h0, ID_valid}, 32'h0);
            check("wait.addr", imem_addr, 32'h20);
            check("wait.pc",   ID_PC, 32'h100);
        end
        imem_ready = 1'b1;
        tick(); check_id("f20", 32'h20, 1'b1);

`ifdef IF_ID_PERF_CNT_EN
        check("perf.fetched", perf_fetched, 32'd6);
        check("perf.bubbles", perf_bubbles, 32'd4);
        check("perf.stalls",  perf_stalls,  32'd3);
`endif

        // wrap at top of address space
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        tick(); check_id("wrapA", 32'hFFFF_FFFC, 1'b1);
        check("wrapA.pc4", ID_PC4, 32'h0);
        tick(); check_id("wrapB", 32'h0, 1'b1);

        // async reset between edges during a stall
        stall = 1'b1;
        @(posedge clk); #2;
        reset = 1'b1; #1;
        check("arst.vld",  {31'h0, ID_valid}, 32'h0);
        check("arst.pc",   ID_PC, 32'h0);
        check("arst.pc4",  ID_PC4, 32'h0);
        check("arst.ins",  ID_instruction, 32'h0);
        check("arst.addr", imem_addr, 32'h0);
        check("arst.req",  {31'h0, imem_req}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
